sqrt_sched: RTL and testbench

Round-robin scheduler that shares one iterative square-root engine among `N_CH` distance-sensor channels in the helicopter ground-distance path. Each channel raises a request with an 8-bit squared-distance operand. The block grants one channel at a time and runs a 16-step bit-serial root. It returns floor(sqrt(operand·2^16)), an 8.8 fixed-point root, tagged with the channel index, over a valid/ready handshake.

---
 rtl/sqrt_sched_pkg.sv | 25 ++
 rtl/sqrt_iter_unit.sv | 82 ++++++++
 rtl/sqrt_sched.sv | 143 ++++++++++++++
 tb/tb_sqrt_sched.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_sched_pkg.sv
// sqrt_sched_pkg
// Shared types and constants for the round-robin square-root scheduler.
//   state_t   : scheduler FSM states
//   IN_W      : operand width
//   OUT_W     : result width, also the number of root iterations
//   SHIFT     : fixed-point scaling applied to the operand (op << SHIFT)
//   ch_width  : width of a channel index for a given channel count
package sqrt_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int IN_W  = 8;
  localparam int OUT_W = 16;
  localparam int SHIFT = 16;

  // Channel index width; never narrower than one bit.
  function automatic int ch_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sqrt_iter_unit.sv
// sqrt_iter_unit
// Bit-serial square-root datapath. Computes floor(sqrt(operand << SHIFT)),
// one result bit per cycle, MSB first, over OUT_W cycles.
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   synchronous active-low reset; discards any calculation
//   start    in   load operand, clear y and the step counter, begin iterating
//   operand  in   IN_W-bit operand, sampled only when start is high
//   done     out  high during the cycle whose edge performs the last step
//   root     out  value y takes at the coming edge; equals the final root
//                 while done is high
module sqrt_iter_unit
  import sqrt_sched_pkg::*;
#(
  parameter int IN_W  = sqrt_sched_pkg::IN_W,
  parameter int OUT_W = sqrt_sched_pkg::OUT_W,
  parameter int SHIFT = sqrt_sched_pkg::SHIFT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [IN_W-1:0]  operand,
  output logic             done,
  output logic [OUT_W-1:0] root
);

  // Square of an OUT_W-bit trial needs the full 2*OUT_W bits.
  localparam int SQ_W   = 2 * OUT_W;
  localparam int STEP_W = $clog2(OUT_W);

  logic [OUT_W-1:0]  y_reg;
  logic [OUT_W-1:0]  y_next;
  logic [STEP_W-1:0] step_reg;
  logic              run_reg;
  logic [SQ_W-1:0]   target_reg;

  logic [OUT_W-1:0]  bit_mask;
  logic [OUT_W-1:0]  trial;
  logic [SQ_W-1:0]   trial_sq;
  logic              last_step;

  // Step s decides result bit OUT_W-1-s.
  generate
    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_mask
      assign bit_mask[gi] = (step_reg == STEP_W'(OUT_W - 1 - gi));
    end
  endgenerate

  always_comb begin
    trial    = y_reg | bit_mask;
    trial_sq = SQ_W'(trial) * SQ_W'(trial);
    y_next   = (trial_sq <= target_reg) ? trial : y_reg;
  end

  assign last_step = (step_reg == STEP_W'(OUT_W - 1));
  assign done      = run_reg && last_step;
  // The scheduler captures the result on the same edge as the last step,
  // so it takes the value being written rather than y_reg.
  assign root      = y_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_reg      <= '0;
      step_reg   <= '0;
      run_reg    <= 1'b0;
      target_reg <= '0;
    end else if (start) begin
      y_reg      <= '0;
      step_reg   <= '0;
      run_reg    <= 1'b1;
      target_reg <= SQ_W'(operand) << SHIFT;
    end else if (run_reg) begin
      y_reg <= y_next;
      if (last_step) begin
        run_reg <= 1'b0;
      end else begin
        step_reg <= step_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sqrt_sched.sv
// sqrt_sched
// Round-robin scheduler sharing one bit-serial square-root engine among
// N_CH requesting channels. Returns floor(sqrt(op * 2^16)) as 8.8 fixed
// point, tagged with the channel index, over a valid/ready handshake.
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   req        in   per-channel request, held until ack
//   op_in      in   packed operands, channel k at [k*IN_W +: IN_W]
//   ack        out  one-cycle one-hot pulse: operand captured
//   busy       out  high whenever the FSM is not idle
//   res_valid  out  result available
//   res_ready  in   downstream accepts the result
//   res_data   out  root of the granted operand
//   res_ch     out  channel that produced res_data
module sqrt_sched
  import sqrt_sched_pkg::*;
#(
  parameter  int N_CH  = 4,
  parameter  int IN_W  = sqrt_sched_pkg::IN_W,
  parameter  int OUT_W = sqrt_sched_pkg::OUT_W,
  localparam int CH_W  = ch_width(N_CH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_CH-1:0]      req,
  input  logic [N_CH*IN_W-1:0] op_in,
  output logic [N_CH-1:0]      ack,
  output logic                 busy,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [OUT_W-1:0]     res_data,
  output logic [CH_W-1:0]      res_ch
);

  state_t            state_reg, state_next;
  logic [CH_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [N_CH-1:0]   ack_reg, ack_next;
  logic [OUT_W-1:0]  res_data_reg, res_data_next;
  logic [CH_W-1:0]   res_ch_reg, res_ch_next;

  logic [IN_W-1:0]   op_arr [N_CH];
  logic [CH_W-1:0]   grant;
  logic [N_CH-1:0]   grant_onehot;
  logic              start;
  logic              iter_done;
  logic [OUT_W-1:0]  iter_root;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      assign op_arr[gi]       = op_in[gi*IN_W +: IN_W];
      assign grant_onehot[gi] = (grant == CH_W'(gi));
    end
  endgenerate

  // First requester at or after rr_ptr. Scanning offsets from the far end
  // down to zero lets the smallest offset overwrite the others.
  always_comb begin
    int idx;
    idx   = 0;
    grant = rr_ptr_reg;
    for (int off = N_CH - 1; off >= 0; off--) begin
      idx = int'(rr_ptr_reg) + off;
      if (idx >= N_CH) begin
        idx = idx - N_CH;
      end
      if (req[idx]) begin
        grant = CH_W'(idx);
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    rr_ptr_next   = rr_ptr_reg;
    ack_next      = '0;
    res_data_next = res_data_reg;
    res_ch_next   = res_ch_reg;
    start         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          start       = 1'b1;
          ack_next    = grant_onehot;
          res_ch_next = grant;
          rr_ptr_next = (grant == CH_W'(N_CH - 1)) ? '0 : grant + 1'b1;
          state_next  = CALC;
        end
      end
      CALC: begin
        if (iter_done) begin
          res_data_next = iter_root;
          state_next    = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= '0;
      ack_reg      <= '0;
      res_data_reg <= '0;
      res_ch_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      rr_ptr_reg   <= rr_ptr_next;
      ack_reg      <= ack_next;
      res_data_reg <= res_data_next;
      res_ch_reg   <= res_ch_next;
    end
  end

  sqrt_iter_unit #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SHIFT (sqrt_sched_pkg::SHIFT)
  ) u_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .operand (op_arr[grant]),
    .done    (iter_done),
    .root    (iter_root)
  );

  // All outputs come straight from registers.
  assign ack       = ack_reg;
  assign busy      = (state_reg != IDLE);
  assign res_valid = (state_reg == DONE);
  assign res_data  = res_data_reg;
  assign res_ch    = res_ch_reg;

endmodule

// File: tb/tb_sqrt_sched.sv
// tb_sqrt_sched
// Directed stimulus with a result scoreboard: expected results are queued
// when a request is issued and a negedge monitor pops and compares them on
// every accepted result.
module tb_sqrt_sched;

  localparam int N_CH  = 4;
  localparam int IN_W  = 8;
  localparam int OUT_W = 16;
  localparam int CH_W  = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N_CH-1:0]      req;
  logic [N_CH*IN_W-1:0] op_in;
  logic [N_CH-1:0]      ack;
  logic                 busy;
  logic                 res_valid;
  logic                 res_ready;
  logic [OUT_W-1:0]     res_data;
  logic [CH_W-1:0]      res_ch;

  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic [OUT_W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   rise_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   ack2_cnt = 0;
  logic prev_valid = 1'b0;

  sqrt_sched #(
    .N_CH  (N_CH),
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .op_in     (op_in),
    .ack       (ack),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_ch    (res_ch)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Monitor: record res_valid rising edges and score every accepted result.
  always @(negedge clk) begin
    if (rst_n && ack[2]) ack2_cnt <= ack2_cnt + 1;
    if (rst_n && res_valid && !prev_valid) rise_q.push_back(cyc);
    prev_valid <= rst_n && res_valid;
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        $display("result ch%0d data %0d (expected ch%0d data %0d)",
                 res_ch, res_data, mon_e.ch, mon_e.data);
        check("res_ch", 32'(res_ch), 32'(mon_e.ch));
        check("res_data", 32'(res_data), 32'(mon_e.data));
      end
    end
  end

  // Advance one cycle; inputs change 1 time unit after the edge and a
  // requester drops its request once it sees its ack.
  task automatic tick();
    @(posedge clk);
    #1;
    req = req & ~ack;
  endtask

  task automatic set_op(input int ch, input logic [IN_W-1:0] v);
    op_in[ch*IN_W +: IN_W] = v;
  endtask

  task automatic push_exp(input int ch, input int data);
    exp_t e;
    e.ch   = CH_W'(ch);
    e.data = OUT_W'(data);
    exp_q.push_back(e);
  endtask

  task automatic wait_ack(input int ch, input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      tick();
      if (ack[ch]) seen = 1'b1;
    end
    if (!seen) begin
      check("ack_timeout", 32'd0, 32'd1);
      req[ch] = 1'b0;
    end
  endtask

  task automatic wait_idle(input int max_cyc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      tick();
      if (!busy && req == '0 && exp_q.size() == 0) ok = 1'b1;
    end
    if (!ok) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ack"},       32'(ack),       32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_res_data"},  32'(res_data),  32'd0);
    check({tag, "_res_ch"},    32'(res_ch),    32'd0);
  endtask

  // Directed ch0 operands and hand-computed floor(256*sqrt(op)).
  int dir_op  [5] = '{0, 1, 2, 255, 100};
  int dir_exp [5] = '{0, 256, 362, 4087, 2560};

  initial begin
    int n;
    rst_n     = 1'b0;
    req       = '0;
    op_in     = '0;
    res_ready = 1'b1;
    repeat (3) tick();
    check_outputs_zero("reset");
    rst_n = 1'b1;
    tick();

    // Single request, ch1 operand 4: latency and result.
    set_op(1, 8'd4);
    push_exp(1, 512);
    req[1] = 1'b1;
    tick();
    check("single_ack", 32'(ack), 32'b0010);
    check("single_busy", 32'(busy), 32'd1);
    n = 1;
    while (!res_valid && n < 40) begin
      tick();
      n++;
    end
    check("valid_latency", 32'(n), 32'd17);
    wait_idle(100);

    // Directed values on ch0, one at a time.
    for (int i = 0; i < 5; i++) begin
      set_op(0, IN_W'(dir_op[i]));
      push_exp(0, dir_exp[i]);
      req[0] = 1'b1;
      wait_ack(0, 20);
      wait_idle(100);
    end

    // Back-pressure: ch2 result held while ch3 waits.
    res_ready = 1'b0;
    set_op(2, 8'd9);
    push_exp(2, 768);
    req[2] = 1'b1;
    wait_ack(2, 20);
    n = 0;
    while (!res_valid && n < 40) begin
      tick();
      n++;
    end
    set_op(3, 8'd16);
    push_exp(3, 1024);
    req[3] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_valid", 32'(res_valid), 32'd1);
      check("stall_data", 32'(res_data), 32'd768);
      check("stall_ch", 32'(res_ch), 32'd2);
      check("stall_busy", 32'(busy), 32'd1);
      check("stall_ack", 32'(ack), 32'd0);
    end
    res_ready = 1'b1;
    wait_idle(200);

    // Reset in the 5th CALC cycle discards the result and rr_ptr.
    set_op(1, 8'd4);
    req[1] = 1'b1;
    wait_ack(1, 20);
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    check_outputs_zero("midcalc_reset");
    rst_n = 1'b1;

    // All four together after reset: order 0,1,2,3, 18 cycles apart.
    for (int k = 0; k < N_CH; k++) begin
      set_op(k, IN_W'((k + 1) * (k + 1)));
      push_exp(k, 256 * (k + 1));
    end
    rise_q.delete();
    req = 4'b1111;
    tick();
    check("rr_first_ack", 32'(ack), 32'b0001);
    wait_idle(200);
    check("rise_count", 32'(rise_q.size()), 32'd4);
    if (rise_q.size() == 4) begin
      for (int k = 1; k < 4; k++) begin
        check("rise_spacing", 32'(rise_q[k] - rise_q[k-1]), 32'd18);
      end
    end

    // Withdrawn request on ch2 during ch0 CALC gets no grant.
    ack2_cnt = 0;
    set_op(0, 8'd100);
    push_exp(0, 2560);
    req[0] = 1'b1;
    wait_ack(0, 20);
    repeat (2) tick();
    set_op(2, 8'd50);
    req[2] = 1'b1;
    repeat (3) tick();
    req[2] = 1'b0;
    wait_idle(100);
    repeat (5) begin
      tick();
      check("withdraw_busy", 32'(busy), 32'd0);
      check("withdraw_ack", 32'(ack), 32'd0);
    end
    check("withdraw_ack2_count", 32'(ack2_cnt), 32'd0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
